rv32i_mc_ctrl: RTL and testbench
================================

Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sits on the issuing side of the ALU interface: it decodes the instruction register and drives the 4-bit ALU operation code, the operand selects and all datapath and memory strobes. It replaces hard-wired single-cycle decode and lets instruction and data memory share one port through a req/ready handshake.

Parameters:
RESET_PC_SEL, 0, pc_sel value driven in IDLE. Kept as a hook only; no functional effect.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instr  in  32  instruction register contents (valid from the cycle after ir_we)
alu_zero  in  1  ALU result == 0
mem_ready  in  1  memory completes the current request this cycle
alu_ctrl  out  4  ALU op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 LTU, 1001 LT, 1010 GEU, 1011 GE, 1100 JALR-add-mask
alu_src_a  out  2  00 rs1, 01 PC, 10 zero
alu_src_b  out  1  0 rs2, 1 immediate
imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J
pc_sel  out  2  00 PC+4, 01 PC+imm (branch/JAL adder), 10 ALU result
pc_we  out  1  PC update strobe
ir_we  out  1  instruction register load
mem_req  out  1  memory request
mem_we  out  1  store qualifier
mem_addr_sel  out  1  0 PC, 1 ALU-out register
rf_we  out  1  register-file write (forced 0 when rd==0)
wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
illegal  out  1  sticky illegal-instruction flag
instret  out  32  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- rst_n low: state goes to IDLE asynchronously. All outputs are 0 in IDLE, including illegal and instret. IDLE always moves to FETCH on the next cycle.
- FETCH: mem_req=1, mem_addr_sel=0. Hold until mem_ready=1. In the ready cycle, assert ir_we=1 and go to DECODE. mem_ready is ignored whenever mem_req=0.
- DECODE: one cycle; drive imm_sel. Go to TRAP on an illegal encoding, otherwise to EXEC.
- Illegal encodings:
  - unknown opcode, ECALL/EBREAK
  - branch funct3 010/011
  - JALR funct3≠0
  - load funct3 011/110/111; store funct3 ≥011
  - OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101
  - SLLI funct7≠0; SRLI/SRAI funct7 not 0000000/0100000
- ALU op map (funct3): 000 ADD (SUB if OP and funct7[5]), 001 SLL, 010 LT, 011 LTU, 100 XOR, 101 SRL/SRA by funct7[5], 110 OR, 111 AND.
- EXEC, by opcode:
  - OP/OP-IMM: alu_src_b=0/1 respectively → WB.
  - LUI: src_a=10, src_b=1, ADD → WB.
  - AUIPC: src_a=01, src_b=1, ADD → WB.
  - LOAD/STORE: ADD rs1+imm → MEM.
  - JAL: → WB.
  - JALR: alu_ctrl=1100, src_b=1 → WB.
  - FENCE: pc_we=1, pc_sel=00 → FETCH.
  - BRANCH: BEQ/BNE use SUB; BLT/BGE/BLTU/BGEU use 1001/1011/1000/1010. Taken = alu_zero for BEQ, !alu_zero for all others. pc_we=1, pc_sel=01 if taken else 00 → FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=store. Hold until mem_ready.
  - Load → WB.
  - Store: pc_we=1, pc_sel=00 in the ready cycle → FETCH.
- WB: one cycle, then FETCH.
  - rf_we=1 (0 if rd==0), pc_we=1.
  - wb_sel: 01 for load, 10 for JAL/JALR, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
- alu_ctrl and operand selects are held constant from EXEC through MEM/WB of the same instruction.
- TRAP: illegal=1; all strobes 0; stay until reset.
- Latency with zero-wait memory: ALU/jump 4 cycles, load 5, store 4, branch 3.
- Reset mid-operation: the request is abandoned immediately; no strobe is asserted in the reset cycle.

Optional Feature:
CTRL_INSTRET_EN defined: instret increments (wrapping at 2^32) in every cycle with pc_we=1.
Undefined: instret is tied to 0 and no counter flops exist.

Decomposition:
- rv32i_pkg: opcode constants, ALU op code enum (the 13 codes above), state enum, and imm_sel/pc_sel/wb_sel/src encodings.
- Sub-module rv32i_alu_dec: combinational opcode/funct3/funct7 → alu_ctrl plus an illegal-funct flag.

Test Plan:
- Reset: assert rst_n low during MEM with mem_req=1 → all outputs 0 the same cycle. Release → one IDLE cycle, then mem_req=1.
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 → EXEC alu_ctrl=0000, src_a=00, src_b=0. WB rf_we=1, wb_sel=00, pc_we=1, pc_sel=00. 4 cycles total.
- SRAI x5,x5,3 (0x4032D293) → alu_ctrl=0111, src_b=1, imm_sel=000. JALR x1,0(x2) (0x000100E7) → alu_ctrl=1100, WB pc_sel=10, wb_sel=10.
- BLTU x1,x2,+8 (0x0020E463) with alu_zero=0 → alu_ctrl=1000, pc_we=1, pc_sel=01 in EXEC. With alu_zero=1 → pc_sel=00.
- LW with mem_ready low for 3 MEM cycles → mem_req=1, mem_we=0 held, no rf_we. Then WB with wb_sel=01.
- instr 0x00000000 → TRAP, illegal=1 sticky. No pc_we/rf_we/mem_req for 20 cycles. instret is unchanged when CTRL_INSTRET_EN is defined.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: opcodes, ALU op codes, FSM states and select encodings shared by the RV32I control path
package rv32i_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_LTU  = 4'b1000,
    ALU_LT   = 4'b1001,
    ALU_GEU  = 4'b1010,
    ALU_GE   = 4'b1011,
    ALU_JALR = 4'b1100
  } alu_op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_LT;
      3'b011:  arith_op = ALU_LTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_alu_dec.sv
// rv32i_alu_dec: opcode/funct3/funct7 to ALU op code, flagging any encoding the core does not implement
module rv32i_alu_dec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl,
  output logic       bad
);
  logic f7_zero, f7_alt;
  assign f7_zero = funct7 == 7'b0000000;
  assign f7_alt  = funct7 == 7'b0100000;
  always_comb begin
    alu_ctrl = ALU_ADD;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_ctrl = arith_op(funct3, funct7[5]);
        bad = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        // only the shift-right immediate borrows bit 30 as an opcode modifier
        alu_ctrl = arith_op(funct3, funct3 == 3'b101 && funct7[5]);
        bad = (funct3 == 3'b001 && !f7_zero) || (funct3 == 3'b101 && !f7_zero && !f7_alt);
      end
      OPC_LOAD:  bad = funct3 == 3'b011 || funct3[2:1] == 2'b11;
      OPC_STORE: bad = funct3 >= 3'b011;
      OPC_JALR: begin
        alu_ctrl = ALU_JALR;
        bad = funct3 != 3'b000;
      end
      OPC_BRANCH: begin
        alu_ctrl = funct3 == 3'b100 ? ALU_LT : funct3 == 3'b101 ? ALU_GE :
                   funct3 == 3'b110 ? ALU_LTU : funct3 == 3'b111 ? ALU_GEU : ALU_SUB;
        bad = funct3[2:1] == 2'b01;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv32i_mc_ctrl.sv
// rv32i_mc_ctrl: multi-cycle RV32I control FSM sharing one memory port; define CTRL_INSTRET_EN for the retired-instruction counter
module rv32i_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [2:0]  imm_sel,
  output logic [1:0]  pc_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic [31:0] instret
);
  state_e state, next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [3:0] dec_alu;
  logic       dec_bad, dec_src_b, taken;
  logic [1:0] dec_src_a;
  logic [2:0] dec_imm;
  logic [9:0] dec_ops;
  logic       is_load, is_store, is_branch, is_fence, is_jal, is_jalr;
  logic       unused_regs;
  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign funct3      = instr[14:12];
  assign unused_regs = ^instr[24:15];
  assign is_load   = opcode == OPC_LOAD;
  assign is_store  = opcode == OPC_STORE;
  assign is_branch = opcode == OPC_BRANCH;
  assign is_fence  = opcode == OPC_FENCE;
  assign is_jal    = opcode == OPC_JAL;
  assign is_jalr   = opcode == OPC_JALR;
  assign taken     = funct3 == 3'b000 ? alu_zero : !alu_zero;
  rv32i_alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (instr[31:25]),
    .alu_ctrl (dec_alu),
    .bad      (dec_bad)
  );
  always_comb begin
    dec_src_a = SRC_A_RS1;
    dec_src_b = 1'b1;
    dec_imm   = IMM_I;
    case (opcode)
      OPC_OP:     dec_src_b = 1'b0;
      OPC_BRANCH: {dec_src_b, dec_imm} = {1'b0, IMM_B};
      OPC_STORE:  dec_imm = IMM_S;
      OPC_LUI:    {dec_src_a, dec_imm} = {SRC_A_ZERO, IMM_U};
      OPC_AUIPC:  {dec_src_a, dec_imm} = {SRC_A_PC, IMM_U};
      OPC_JAL:    {dec_src_a, dec_imm} = {SRC_A_PC, IMM_J};
      OPC_FENCE:  dec_src_b = 1'b0;
      default:    dec_imm = IMM_I;
    endcase
  end
  // IR is stable from EXEC to WB, so the decoded ALU controls stay constant across those states
  assign dec_ops = {dec_alu, dec_src_a, dec_src_b, dec_imm};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = S_FETCH;
      S_FETCH:  next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: next = dec_bad ? S_TRAP : S_EXEC;
      S_EXEC:   next = (is_load | is_store) ? S_MEM : (is_branch | is_fence) ? S_FETCH : S_WB;
      S_MEM:    next = !mem_ready ? S_MEM : is_store ? S_FETCH : S_WB;
      S_WB:     next = S_FETCH;
      default:  next = state;
    endcase
  end
  always_comb begin
    {alu_ctrl, alu_src_a, alu_src_b, imm_sel} = '0;
    pc_sel       = PC_PLUS4;
    pc_we        = 1'b0;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    illegal      = 1'b0;
    case (state)
      S_IDLE: pc_sel = RESET_PC_SEL;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end
      S_DECODE: imm_sel = dec_imm;
      S_EXEC: begin
        {alu_ctrl, alu_src_a, alu_src_b, imm_sel} = dec_ops;
        pc_we  = is_branch | is_fence;
        pc_sel = (is_branch & taken) ? PC_BR : PC_PLUS4;
      end
      S_MEM: begin
        {alu_ctrl, alu_src_a, alu_src_b, imm_sel} = dec_ops;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        pc_we        = is_store & mem_ready;
      end
      S_WB: begin
        {alu_ctrl, alu_src_a, alu_src_b, imm_sel} = dec_ops;
        rf_we  = |rd;
        pc_we  = 1'b1;
        wb_sel = is_load ? WB_MEM : (is_jal | is_jalr) ? WB_PC4 : WB_ALU;
        pc_sel = is_jal ? PC_BR : is_jalr ? PC_ALU : PC_PLUS4;
      end
      S_TRAP: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end
`ifdef CTRL_INSTRET_EN
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (pc_we) cnt <= cnt + 32'd1;
  assign instret = cnt;
`else
  assign instret = '0;
`endif
endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// tb_rv32i_mc_ctrl: directed checks of the multi-cycle control FSM outputs cycle by cycle
module tb_rv32i_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, alu_zero, mem_ready;
  logic [31:0] instr, instret, cur;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a, pc_sel, wb_sel;
  logic        alu_src_b, pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we, illegal;
  logic [2:0]  imm_sel;
  logic [20:0] obs;
  int          nvec = 0, nerr = 0, ret = 0;
`ifdef CTRL_INSTRET_EN
  localparam bit INST_EN = 1'b1;
`else
  localparam bit INST_EN = 1'b0;
`endif
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SRAI  = 32'h4032D293;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_BLTU  = 32'h0020E463;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_LW    = 32'h0000A203;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_ADDX0 = 32'h00208033;
  localparam logic [31:0] I_BADOP = 32'h40209033;
  rv32i_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
    .pc_sel(pc_sel), .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
  );
  always #5 clk = ~clk;
  assign obs = {alu_ctrl, alu_src_a, alu_src_b, imm_sel, pc_sel, pc_we, ir_we, mem_req,
                mem_we, mem_addr_sel, rf_we, wb_sel, illegal};
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // expected outputs: alu, src_a, src_b, imm, pc_sel, pc_we, ir_we, mem_req, mem_we, addr_sel, rf_we, wb_sel, illegal
  task automatic ex(input string tag, input logic [3:0] a, input logic [1:0] sa, input logic sb,
                    input logic [2:0] im, input logic [1:0] ps, input logic pw, input logic iw,
                    input logic mr, input logic mw, input logic ma, input logic rw,
                    input logic [1:0] wb, input logic il);
    chk(tag, {11'b0, obs}, {11'b0, a, sa, sb, im, ps, pw, iw, mr, mw, ma, rw, wb, il});
  endtask
  task automatic step(input logic rdy, input logic z, input logic [31:0] ins);
    @(negedge clk);
    mem_ready = rdy;
    alu_zero  = z;
    instr     = ins;
    #1;
  endtask
  task automatic fet(input logic [31:0] ins);
    step(1'b1, 1'b0, cur);
    ex("fetch", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cur = ins;
    step(1'b0, 1'b0, cur);
  endtask
  task automatic chk_ret(input string tag);
    chk(tag, instret, INST_EN ? ret : 0);
  endtask
  initial begin
    rst_n = 1'b0;
    cur = '0;
    step(0, 0, cur);
    step(0, 0, cur);
    ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    ex("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fet(I_ADD);
    ex("add_dec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("add_exec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("add_wb", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    ret = 1;
    step(0, 0, cur);
    ex("fetch_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk_ret("instret_add");
    fet(I_SRAI);
    ex("srai_dec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("srai_exec", 4'b0111, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("srai_wb", 4'b0111, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    fet(I_JALR);
    ex("jalr_dec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("jalr_exec", 4'b1100, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("jalr_wb", 4'b1100, 0, 1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 2'b10, 0);
    fet(I_BLTU);
    ex("bltu_dec", 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("bltu_taken", 4'b1000, 0, 0, 3'b010, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    fet(I_BLTU);
    step(0, 1, cur);
    ex("bltu_not_taken", 4'b1000, 0, 0, 3'b010, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
    fet(I_BEQ);
    step(0, 1, cur);
    ex("beq_taken", 4'b0001, 0, 0, 3'b010, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0);
    ret = 6;
    fet(I_LW);
    chk_ret("instret_branches");
    step(0, 0, cur);
    ex("lw_exec", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, cur);
      ex("lw_mem_wait", 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    end
    step(1, 0, cur);
    ex("lw_mem_ready", 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    step(0, 0, cur);
    ex("lw_wb", 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 2'b01, 0);
    fet(I_SW);
    ex("sw_dec", 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("sw_exec", 0, 0, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, cur);
    ex("sw_mem", 0, 0, 1, 3'b001, 0, 1, 0, 1, 1, 1, 0, 0, 0);
    fet(I_ADDX0);
    step(0, 0, cur);
    step(0, 0, cur);
    ex("add_x0_wb", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    ret = 9;
    fet(32'h0);
    ex("ill_dec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_ret("instret_pre_trap");
    for (int i = 0; i < 20; i++) begin
      step(i[0], i[1], cur);
      ex("trap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    chk_ret("instret_trap");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    ex("trap_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = '0;
    #1;
    fet(I_LW);
    step(0, 0, cur);
    step(0, 0, cur);
    ex("mem_before_reset", 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    ex("reset_in_mem", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_in_mem_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    ex("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("fetch_after_reset", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    fet(I_BADOP);
    ex("badop_dec", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, cur);
    ex("badop_trap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
